// File: rtl/mips_cpu_divider.sv
// Iterative restoring divider for MIPS DIV/DIVU, one quotient bit per clock.
// Owns the HI (remainder) and LO (quotient) registers, also written directly by MTHI/MTLO.
module mips_cpu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state  | meaning
  // S_IDLE | waiting for start; MTHI/MTLO accepted here
  // S_RUN  | one shift/subtract step per clock, WIDTH steps
  // S_FIX  | apply result signs, write HI/LO, pulse done
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_DIVU = 6'b011011;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             is_div, is_divu, accept;
  logic             a_neg, b_neg, op2_zero;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;

  assign is_div   = (funct == FN_DIV);
  assign is_divu  = (funct == FN_DIVU);
  assign accept   = (state_q == S_IDLE) && start && (is_div || is_divu);
  assign a_neg    = is_div && op1[WIDTH-1];
  assign b_neg    = is_div && op2[WIDTH-1];
  assign op2_zero = (op2 == '0);
  // Negating the most negative value yields 2^(WIDTH-1) read as unsigned.
  assign a_abs    = a_neg ? -op1 : op1;
  assign b_abs    = b_neg ? -op2 : op2;

  // Remainder stays below the divisor, so WIDTH+1 bits hold the shifted trial.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, dvs_q});
  assign diff     = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          // With a zero divisor every step succeeds: quotient all ones and the
          // raw dividend shifts into the remainder, so skip the abs/sign path.
          quo_d   = op2_zero ? op1 : a_abs;
          rem_d   = '0;
          dvs_d   = b_abs;
          qneg_d  = !op2_zero && (a_neg ^ b_neg);
          rneg_d  = !op2_zero && a_neg;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (!start) begin
          if (hi_we) hi_d = op1;
          if (lo_we) lo_d = op1;
        end
      end
      S_RUN: begin
        rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_divider.sv
// Directed-vector bench for mips_cpu_divider: result table, latency/pulse checks,
// plus hand sequences for start/MTHI while busy, MTHI/MTLO in idle and reset mid-run.
module tb_mips_cpu_divider;

  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_DIVU = 6'b011011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] op1, op2;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;

  mips_cpu_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .op1(op1), .op2(op2), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mlo, output logic [31:0] mhi);
    if (b == 32'd0) begin
      mlo = 32'hFFFF_FFFF; mhi = a;
    end else if (f == F_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        mlo = 32'h8000_0000; mhi = 32'd0;
      end else begin
        mlo = $signed(a) / $signed(b);
        mhi = $signed(a) % $signed(b);
      end
    end else begin
      mlo = a / b; mhi = a % b;
    end
  endfunction

  // Called 1 time unit after a rising edge with the divider idle.
  // poke_kind: 0 none, 1 second start at poke_cyc, 2 MTHI 0xAAAA at poke_cyc.
  task automatic run_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int poke_cyc, input int poke_kind,
                         output logic [31:0] rlo, output logic [31:0] rhi,
                         output int lat, output bit busy_ok, output bit hold_ok);
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    funct = f; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_ok = (busy === 1'b1); hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == poke_cyc && poke_kind == 1) begin
        funct = F_DIVU; op1 = 32'd5; op2 = 32'd1; start = 1'b1;
      end
      if (lat == poke_cyc && poke_kind == 2) begin
        op1 = 32'h0000_AAAA; hi_we = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      lat++;
      if (done !== 1'b1) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
      end
    end
    rlo = lo; rhi = hi;
  endtask

  task automatic div_and_check(input string name, input logic [5:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                               input bit full);
    logic [31:0] rlo, rhi;
    int lat, d0;
    bit bok, hok;
    d0 = done_cnt;
    run_div(f, a, b, -1, 0, rlo, rhi, lat, bok, hok);
    chk({name, " lo"}, rlo, elo);
    chk({name, " hi"}, rhi, ehi);
    if (full) begin
      chk({name, " latency"}, 32'(lat), 32'd33);
      chk({name, " busy during run"}, {31'd0, bok}, 32'd1);
      chk({name, " hold during run"}, {31'd0, hok}, 32'd1);
      chk({name, " busy low with done"}, {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk({name, " done one cycle"}, {31'd0, done}, 32'd0);
      chk({name, " done count"}, 32'(done_cnt - d0), 32'd1);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] rlo, rhi, mlo, mhi, a, b, hi_save, lo_save;
    int lat, d0;
    bit bok, hok;
    logic [5:0] f;

    vecs.push_back('{F_DIVU, 32'd100,        32'd7,          32'd14,         32'd2});
    vecs.push_back('{F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF});
    vecs.push_back('{F_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1});
    vecs.push_back('{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0});
    vecs.push_back('{F_DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678});
    vecs.push_back('{F_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9});
    vecs.push_back('{F_DIVU, 32'd0,          32'd5,          32'd0,          32'd0});
    vecs.push_back('{F_DIVU, 32'd3,          32'd10,         32'd0,          32'd3});
    vecs.push_back('{F_DIV,  32'h0000_3039,  32'd1,          32'h0000_3039,  32'd0});
    vecs.push_back('{F_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0});
    vecs.push_back('{F_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0});
    vecs.push_back('{F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000});
    vecs.push_back('{F_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE});
    vecs.push_back('{F_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0});
    vecs.push_back('{F_DIVU, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  32'd5});
    vecs.push_back('{F_DIV,  32'hFFFF_FFFD,  32'd7,          32'd0,          32'hFFFF_FFFD});

    reset = 1'b1; start = 1'b0; funct = 6'd0; op1 = '0; op2 = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      div_and_check($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                    vecs[i].exp_lo, vecs[i].exp_hi, 1'b1);

    // MTHI / MTLO in idle
    op1 = 32'h0000_AAAA; hi_we = 1'b1;
    @(posedge clk); #1; hi_we = 1'b0;
    chk("mthi idle hi", hi, 32'h0000_AAAA);
    op1 = 32'h0000_5555; lo_we = 1'b1;
    @(posedge clk); #1; lo_we = 1'b0;
    chk("mtlo idle lo", lo, 32'h0000_5555);
    chk("mtlo keeps hi", hi, 32'h0000_AAAA);
    op1 = 32'hDEAD_BEEF; hi_we = 1'b1; lo_we = 1'b1;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi+mtlo hi", hi, 32'hDEAD_BEEF);
    chk("mthi+mtlo lo", lo, 32'hDEAD_BEEF);

    // invalid funct start is ignored, and blocks a simultaneous MTHI
    funct = 6'b100000; op1 = 32'h1111_1111; op2 = 32'd3; start = 1'b1; hi_we = 1'b1;
    @(posedge clk); #1; start = 1'b0; hi_we = 1'b0;
    chk("bad funct busy", {31'd0, busy}, 32'd0);
    chk("bad funct hi", hi, 32'hDEAD_BEEF);
    repeat (35) @(posedge clk);
    #1;
    chk("bad funct no result", lo, 32'hDEAD_BEEF);

    // accepted start wins over a same-cycle MTHI
    hi_we = 1'b1;
    d0 = done_cnt;
    run_div(F_DIVU, 32'd50, 32'd8, -1, 0, rlo, rhi, lat, bok, hok);
    chk("start wins lo", rlo, 32'd6);
    chk("start wins hi", rhi, 32'd2);
    @(posedge clk); #1;

    // second start while busy is ignored
    d0 = done_cnt;
    run_div(F_DIVU, 32'd100, 32'd7, 10, 1, rlo, rhi, lat, bok, hok);
    chk("restart lo", rlo, 32'd14);
    chk("restart hi", rhi, 32'd2);
    chk("restart latency", 32'(lat), 32'd33);
    repeat (40) @(posedge clk);
    #1;
    chk("restart done count", 32'(done_cnt - d0), 32'd1);
    chk("restart busy idle", {31'd0, busy}, 32'd0);

    // MTHI while busy is dropped
    run_div(F_DIVU, 32'd100, 32'd7, 5, 2, rlo, rhi, lat, bok, hok);
    chk("mthi busy hold", {31'd0, hok}, 32'd1);
    chk("mthi busy hi", rhi, 32'd2);
    @(posedge clk); #1;

    // reset in the middle of a run
    op1 = 32'h0000_1234; hi_we = 1'b1; lo_we = 1'b1;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    funct = F_DIVU; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midreset no done", 32'(done_cnt - d0), 32'd0);
    chk("midreset lo stays", lo, 32'd0);
    div_and_check("after reset", F_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);

    // random pairs against the reference model
    for (int i = 0; i < 24; i++) begin
      f = ($urandom_range(0, 1) == 0) ? F_DIV : F_DIVU;
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd1;
        1: b = a + 32'($urandom_range(1, 1000));
        2: b = 32'($urandom_range(1, 20));
        3: b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if (i == 0) a = 32'd0;
      model(f, a, b, mlo, mhi);
      div_and_check($sformatf("rand%0d f=%0h a=%08h b=%08h", i, f, a, b), f, a, b, mlo, mhi, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
